change_dispenser: RTL and testbench
===================================

# change_dispenser

Sequential change-return unit for the Flag Vending Machine. On a start command it subtracts the item price from the inserted credit using a bit-serial full subtractor with a registered borrow, the subtract-direction counterpart of the datapath adders. It then pays the difference out greedily as a stream of coin codes over a valid/ready handshake to the coin-ejector logic, or flags insufficient credit.

## Interface

- W, 8, width of credit, price and internal remainder; legal range W ≥ 5.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset is synchronous and active-low.
- start  in  1  request; accepted only in IDLE.
- credit  in  W  inserted credit in cents; sampled on accepted start.
- price  in  W  item price in cents; sampled on accepted start.
- busy  out  1  high in SUB, DISP, FIN.
- coin_valid  out  1  coin offer present.
- coin_value  out  2  coin code: 0=1c, 1=5c, 2=10c, 3=25c.
- coin_ready  in  1  ejector accepts the offered coin.
- done  out  1  one-cycle pulse at end of transaction.
- insufficient  out  1  high with done when credit < price.

## Operation

- States: IDLE, SUB, DISP, FIN. Reset or rst_n low at any edge forces IDLE, clears borrow, bit counter, operand and remainder registers. All outputs are 0 in reset and in IDLE.
- IDLE: start high → latch credit into A and price into B, borrow := 0, bit index := 0 → SUB. Otherwise hold.
- SUB: one bit per cycle, LSB first. d_i = a_i ^ b_i ^ borrow; borrow := (~a_i & b_i) | (~(a_i ^ b_i) & borrow). d_i is written into remainder bit i. After bit W-1 is processed: final borrow 1 → FIN with insufficient set; else → DISP.
- DISP: coin_valid = (rem != 0). coin_value = largest coin ≤ rem (rem ≥ 25 → 3, ≥ 10 → 2, ≥ 5 → 1, else 0); computed from registered rem and stable while coin_valid && !coin_ready. On edge with coin_valid && coin_ready: rem := rem − coin value. On edge with rem == 0: → FIN.
- FIN: done = 1, insufficient = stored flag, busy = 1 for exactly one cycle; → IDLE and clear flag.
- start is ignored whenever state ≠ IDLE. credit/price changes after acceptance have no effect.
- rem arithmetic is W bits, unsigned; subtraction in DISP never underflows because offered coin ≤ rem.

## Timing

- start sampled high at edge ending cycle T: busy high from T+1. SUB occupies T+1..T+W (bit i in cycle T+1+i).
- Insufficient: FIN at T+W+1; done and insufficient high only in that cycle; coin_valid never asserted.
- Exact payment (rem == 0): DISP at T+W+1 with coin_valid 0, FIN at T+W+2.
- Change: first coin_valid at T+W+1. With coin_ready held high, one coin per cycle; for N coins, FIN at T+W+1+N.
- A handshake takes effect at the edge; the next coin_value appears in the following cycle. After FIN, IDLE, so a new start can be accepted no earlier than the cycle after FIN.
- Reset mid-transaction: next cycle is IDLE with all outputs 0, and no done pulse is issued.

## Test plan

- W=8, credit=100, price=59, coin_ready=1 → coin codes 3,2,1,0 on consecutive cycles from T+9; done at T+13, insufficient=0.
- credit=50, price=75 → no coin_valid; done=1 and insufficient=1 at T+9 only; busy low at T+10.
- credit=40, price=40 → no coin_valid; done at T+10, insufficient=0.
- credit=255, price=0, coin_ready low for 3 cycles at first offer → coin_valid=1 and coin_value=3 held stable; then ten code-3 coins, one code-1 coin, done.
- Assert rst_n=0 in the cycle of the second coin of the 100/59 case → next cycle IDLE; busy, coin_valid, done all 0; no further coins.
- Pulse start during SUB with different operands → ignored; original transaction result unchanged.

Source files
------------

// File: rtl/change_dispenser.sv
// change_dispenser: bit-serial credit-minus-price subtractor followed by a
// greedy coin payout over a valid/ready handshake to the coin ejector.
module change_dispenser #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] credit,
    input  logic [W-1:0] price,
    output logic         busy,
    output logic         coin_valid,
    output logic [1:0]   coin_value,
    input  logic         coin_ready,
    output logic         done,
    output logic         insufficient
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DISP = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [W-1:0]    opa;
    logic [W-1:0]    opb;
    logic [W-1:0]    rem;
    logic            borrow;
    logic [CW-1:0]   bit_idx;
    logic            short_flag;

    logic            a_bit;
    logic            b_bit;
    logic            d_bit;
    logic            borrow_nxt;
    logic            last_bit;
    logic            rem_zero;
    logic [W-1:0]    coin_amt;
    logic [1:0]      coin_code;
    logic            take;

    // One full-subtractor slice on the current bit, plus greedy coin selection
    always_comb begin
        a_bit      = opa[bit_idx];
        b_bit      = opb[bit_idx];
        d_bit      = a_bit ^ b_bit ^ borrow;
        borrow_nxt = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow);
        last_bit   = (bit_idx == CW'(W - 1));
        rem_zero   = (rem == '0);
        coin_code  = 2'd0;
        coin_amt   = W'(1);
        if (rem >= W'(25)) begin
            coin_code = 2'd3;
            coin_amt  = W'(25);
        end else if (rem >= W'(10)) begin
            coin_code = 2'd2;
            coin_amt  = W'(10);
        end else if (rem >= W'(5)) begin
            coin_code = 2'd1;
            coin_amt  = W'(5);
        end
        take = (state == DISP) && !rem_zero && coin_ready;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; the last accepted coin goes straight to FIN
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = SUB;
            SUB:  if (last_bit) state_nxt = borrow_nxt ? FIN : DISP;
            DISP: if (rem_zero || (take && (rem == coin_amt))) state_nxt = FIN;
            FIN:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch, serial subtract, remainder payout and shortfall flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opa        <= '0;
            opb        <= '0;
            rem        <= '0;
            borrow     <= 1'b0;
            bit_idx    <= '0;
            short_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        opa        <= credit;
                        opb        <= price;
                        rem        <= '0;
                        borrow     <= 1'b0;
                        bit_idx    <= '0;
                        short_flag <= 1'b0;
                    end
                end
                SUB: begin
                    rem[bit_idx] <= d_bit;
                    borrow       <= borrow_nxt;
                    bit_idx      <= bit_idx + CW'(1);
                    if (last_bit) begin
                        short_flag <= borrow_nxt;
                    end
                end
                DISP: begin
                    if (take) begin
                        rem <= rem - coin_amt;
                    end
                end
                FIN: begin
                    short_flag <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Output decode from registered state and remainder
    always_comb begin
        busy         = 1'b0;
        coin_valid   = 1'b0;
        coin_value   = 2'd0;
        done         = 1'b0;
        insufficient = 1'b0;
        case (state)
            SUB: busy = 1'b1;
            DISP: begin
                busy       = 1'b1;
                coin_valid = !rem_zero;
                coin_value = rem_zero ? 2'd0 : coin_code;
            end
            FIN: begin
                busy         = 1'b1;
                done         = 1'b1;
                insufficient = short_flag;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser; observes {busy, coin_valid,
// coin_value, done, insufficient} each cycle on the falling edge.
module tb_change_dispenser;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] credit;
    logic [W-1:0] price;
    logic         busy;
    logic         coin_valid;
    logic [1:0]   coin_value;
    logic         coin_ready;
    logic         done;
    logic         insufficient;
    logic [5:0]   obs;

    int vectors = 0;
    int errors  = 0;

    change_dispenser #(.W(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .credit       (credit),
        .price        (price),
        .busy         (busy),
        .coin_valid   (coin_valid),
        .coin_value   (coin_value),
        .coin_ready   (coin_ready),
        .done         (done),
        .insufficient (insufficient)
    );

    always #5 clk = ~clk;

    assign obs = {busy, coin_valid, coin_value, done, insufficient};

    // Expected outputs for 100-59=41 -> 25,10,5,1 with ready held high
    function automatic logic [5:0] exp_change(input int k);
        if (k >= 1 && k <= 8) return 6'b100000;
        case (k)
            9:  return 6'b111100;
            10: return 6'b111000;
            11: return 6'b110100;
            12: return 6'b110000;
            13: return 6'b100010;
            default: return 6'b000000;
        endcase
    endfunction

    // Drive start during cycle T; returns at the falling edge of cycle T+1
    task automatic start_txn(input logic [W-1:0] c, input logic [W-1:0] p);
        @(negedge clk);
        start  = 1'b1;
        credit = c;
        price  = p;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] exp;
        rst_n = 1'b0;
        start = 1'b1;
        credit = 8'd100;
        price = 8'd1;
        coin_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            exp = 6'b000000;
            vectors++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset cycle %0d: got %b want %b", k, obs, exp);
            end
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (obs !== 6'b000000) begin
            errors++;
            $display("FAIL idle_after_reset: got %b want 000000", obs);
        end
    endtask

    task automatic test_change();
        logic [5:0] exp;
        coin_ready = 1'b1;
        start_txn(8'd100, 8'd59);
        for (int k = 1; k <= 15; k++) begin
            exp = exp_change(k);
            vectors++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL change T+%0d: got %b want %b", k, obs, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_insufficient();
        logic [5:0] exp;
        coin_ready = 1'b1;
        start_txn(8'd50, 8'd75);
        for (int k = 1; k <= 11; k++) begin
            exp = (k <= 8) ? 6'b100000 : (k == 9) ? 6'b100011 : 6'b000000;
            vectors++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL insufficient T+%0d: got %b want %b", k, obs, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_exact();
        logic [5:0] exp;
        coin_ready = 1'b1;
        start_txn(8'd40, 8'd40);
        for (int k = 1; k <= 12; k++) begin
            exp = (k <= 9) ? 6'b100000 : (k == 10) ? 6'b100010 : 6'b000000;
            vectors++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL exact T+%0d: got %b want %b", k, obs, exp);
            end
            @(negedge clk);
        end
    endtask

    // 255-0: ejector stalls three cycles on the first offer, then ten 25c and one 5c
    task automatic test_stall();
        logic [5:0] exp;
        coin_ready = 1'b0;
        start_txn(8'd255, 8'd0);
        for (int k = 1; k <= 24; k++) begin
            if (k <= 8)       exp = 6'b100000;
            else if (k <= 20) exp = 6'b111100;
            else if (k == 21) exp = 6'b110100;
            else if (k == 22) exp = 6'b100010;
            else              exp = 6'b000000;
            vectors++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL stall T+%0d: got %b want %b", k, obs, exp);
            end
            if (k == 11) coin_ready = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_mid_reset();
        logic [5:0] exp;
        coin_ready = 1'b1;
        start_txn(8'd100, 8'd59);
        for (int k = 1; k <= 16; k++) begin
            exp = (k <= 10) ? exp_change(k) : 6'b000000;
            vectors++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL mid_reset T+%0d: got %b want %b", k, obs, exp);
            end
            if (k == 10) rst_n = 1'b0;
            if (k == 11) rst_n = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_ignored_start();
        logic [5:0] exp;
        coin_ready = 1'b1;
        start_txn(8'd100, 8'd59);
        for (int k = 1; k <= 15; k++) begin
            exp = exp_change(k);
            vectors++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL ignored_start T+%0d: got %b want %b", k, obs, exp);
            end
            if (k == 3) begin
                start  = 1'b1;
                credit = 8'd10;
                price  = 8'd200;
            end
            if (k == 4) start = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_change();
        test_insufficient();
        test_exact();
        test_stall();
        test_mid_reset();
        test_ignored_start();
        test_exact();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
